// File: rtl/term_ctrl.sv
// MMIO terminal controller: keyboard bytes are queued into an RX FIFO, CPU
// writes are queued into a TX FIFO that is paced out to the terminal.
module term_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0030,
    parameter int          DEPTH     = 8,
    parameter int          TX_GAP    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [15:0] key_data,
    input  logic        key_av,
    output logic        key_en,
    input  logic        term_rdy,
    output logic [7:0]  term_data,
    output logic        term_en
);

    localparam int                PW        = $clog2(DEPTH);
    localparam int                GW        = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [3:0]        DEPTH_C   = 4'(DEPTH);
    localparam logic [GW-1:0]     GAP_INIT  = (TX_GAP > 0) ? GW'(TX_GAP - 1) : '0;
    localparam logic [31:0]       STAT_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {K_IDLE, K_ACK, K_WAIT} key_state_e;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_e;

    key_state_e key_state_q, key_state_d;
    tx_state_e  tx_state_q, tx_state_d;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [3:0]    rx_cnt_q, tx_cnt_q;
    logic          tx_ovf_q;
    logic [31:0]   dout_q, dout_d;
    logic [7:0]    term_data_q, term_data_d;
    logic [GW-1:0] gap_q, gap_d;

    logic sel_d, sel_s, rd;
    logic rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
    logic rx_nempty, tx_empty, tx_full, tx_go, ovf_set, ovf_clr;
    logic [31:0] status;
    logic unused_bits;

    assign sel_d       = (addr == BASE_ADDR);
    assign sel_s       = (addr == STAT_ADDR);
    assign rd          = re & ~we;
    assign rx_nempty   = (rx_cnt_q != 4'd0);
    assign tx_empty    = (tx_cnt_q == 4'd0);
    assign tx_full     = (tx_cnt_q == DEPTH_C);
    assign tx_go       = ~tx_empty & term_rdy;
    assign rx_push     = (key_state_q == K_ACK);
    assign rx_pop      = rd & sel_d & rx_nempty;
    assign tx_push_req = we & sel_d;
    // A full TX drops the byte even if the pacing FSM frees a slot this cycle.
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = (tx_state_q == T_SEND);
    assign ovf_set     = tx_push_req & tx_full;
    assign ovf_clr     = we & sel_s & din[3];
    assign status      = {12'b0, tx_cnt_q, 4'b0, rx_cnt_q, 4'b0,
                          tx_ovf_q, tx_empty, tx_full, rx_nempty};
    assign unused_bits = ^{key_data[15:8], din[31:8]};

    assign dout      = dout_q;
    assign term_data = term_data_q;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= key_data[7:0];
        if (tx_push) tx_mem[tx_wr_q] <= din[7:0];
    end

    always_comb begin
        dout_d = '0;
        if (rd && sel_d && rx_nempty) dout_d = {24'b0, rx_mem[rx_rd_q]};
        else if (rd && sel_s)         dout_d = status;
    end

    always_comb begin
        key_state_d = key_state_q;
        key_en      = 1'b0;
        case (key_state_q)
            K_IDLE: if (key_av && (rx_cnt_q < DEPTH_C)) key_state_d = K_ACK;
            K_ACK: begin
                key_en      = 1'b1;
                key_state_d = K_WAIT;
            end
            K_WAIT:  key_state_d = K_IDLE;
            default: key_state_d = K_IDLE;
        endcase
    end

    // The last gap cycle may launch the next byte directly, so pulses sit
    // TX_GAP+1 cycles apart.
    always_comb begin
        tx_state_d  = tx_state_q;
        gap_d       = gap_q;
        term_en     = 1'b0;
        term_data_d = term_data_q;
        case (tx_state_q)
            T_IDLE: if (tx_go) tx_state_d = T_SEND;
            T_SEND: begin
                term_en = 1'b1;
                if (TX_GAP > 0) begin
                    tx_state_d = T_GAP;
                    gap_d      = GAP_INIT;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_GAP: begin
                if (gap_q == '0) tx_state_d = tx_go ? T_SEND : T_IDLE;
                else             gap_d      = gap_q - GW'(1);
            end
            default: tx_state_d = T_IDLE;
        endcase
        if (tx_state_q != T_SEND && tx_state_d == T_SEND) term_data_d = tx_mem[tx_rd_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_state_q <= K_IDLE;
            tx_state_q  <= T_IDLE;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            dout_q      <= '0;
            term_data_q <= '0;
            gap_q       <= '0;
        end else begin
            key_state_q <= key_state_d;
            tx_state_q  <= tx_state_d;
            dout_q      <= dout_d;
            term_data_q <= term_data_d;
            gap_q       <= gap_d;
            if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
            if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
            rx_cnt_q <= rx_cnt_q + {3'b0, rx_push} - {3'b0, rx_pop};
            tx_cnt_q <= tx_cnt_q + {3'b0, tx_push} - {3'b0, tx_pop};
            if (ovf_set)      tx_ovf_q <= 1'b1;
            else if (ovf_clr) tx_ovf_q <= 1'b0;
        end
    end

endmodule
